// File: rtl/matrix_display_pkg.sv
// ---------------------------------------------------------------------------
// matrix_display_pkg
// Shared definitions for the 7x3 LED matrix display scheduler:
//   - mode-select encodings driven to the water/irrigation multiplexer
//   - one-hot column-enable patterns
//   - scheduler FSM state type
//   - counter width helper (never narrower than 1 bit)
// ---------------------------------------------------------------------------
package matrix_display_pkg;

  localparam logic MODE_WATER      = 1'b0;
  localparam logic MODE_IRRIGATION = 1'b1;

  localparam logic [2:0] COL2 = 3'b100;
  localparam logic [2:0] COL1 = 3'b010;
  localparam logic [2:0] COL0 = 3'b001;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BLANK  = 2'd1,
    ST_ACTIVE = 2'd2
  } sched_state_e;

  // Width of a counter that spans 0..modulus-1.
  function automatic int cnt_width(input int modulus);
    return (modulus > 1) ? $clog2(modulus) : 1;
  endfunction

endpackage

// File: rtl/modulo_counter.sv
// ---------------------------------------------------------------------------
// modulo_counter
// Free-running modulo-MODULUS counter with synchronous clear.
//   clock    in   clock, rising edge
//   reset_n  in   asynchronous active-low reset
//   en_i     in   advance the count this cycle
//   clr_i    in   synchronous clear to 0 (wins over en_i)
//   count_o  out  current count, 0..MODULUS-1
//   wrap_o   out  combinational: this enabled cycle is the last of the modulus
// ---------------------------------------------------------------------------
module modulo_counter
  import matrix_display_pkg::*;
#(
  parameter int MODULUS = 4,
  localparam int W      = cnt_width(MODULUS)
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         en_i,
  input  logic         clr_i,
  output logic [W-1:0] count_o,
  output logic         wrap_o
);

  localparam logic [W-1:0] LAST = W'(MODULUS - 1);

  logic [W-1:0] count_q, count_d;

  assign wrap_o  = en_i && !clr_i && (count_q == LAST);
  assign count_o = count_q;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge inputs regardless of process evaluation order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/matrix_display_scheduler.sv
// ---------------------------------------------------------------------------
// matrix_display_scheduler
// Scans three muxed 7-bit column words onto a 7x3 LED matrix, one column at a
// time (2, 1, 0) with a one-cycle blank between columns, and alternates the
// water/irrigation display mode every DWELL_FRAMES frames.
//   clock             in   system clock, rising edge
//   reset_n           in   asynchronous active-low reset
//   enable            in   run scanning; low forces IDLE
//   hold_mode         in   freeze dwell counter and mode
//   force_irrigation  in   select irrigation at the next frame boundary
//   column_2/1/0      in   7-bit column words from the mode multiplexer
//   mode_select       out  mux select, 0 = water, 1 = irrigation
//   column_enable     out  one-hot active column, bit 2 = column_2
//   row_data          out  row pattern of the active column
//   frame_done        out  pulse on the last active cycle of column 0
// All outputs are registered.
// ---------------------------------------------------------------------------
module matrix_display_scheduler
  import matrix_display_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int DWELL_FRAMES = 500
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       hold_mode,
  input  logic       force_irrigation,
  input  logic [6:0] column_2,
  input  logic [6:0] column_1,
  input  logic [6:0] column_0,
  output logic       mode_select,
  output logic [2:0] column_enable,
  output logic [6:0] row_data,
  output logic       frame_done
);

  localparam int SW = cnt_width(SCAN_DIV);
  localparam int DW = cnt_width(DWELL_FRAMES);
  // Count value one cycle before the last active cycle of a slot.
  localparam logic [SW-1:0] SCAN_PRE = (SCAN_DIV >= 2) ? SW'(SCAN_DIV - 2) : '0;

  sched_state_e state_q, state_d;
  logic [1:0]   pos_q, pos_d;      // scan position: 0 -> column 2, 2 -> column 0
  logic         mode_q, mode_d;
  logic [2:0]   col_en_q, col_en_d;
  logic [6:0]   row_q, row_d;
  logic         fd_q, fd_d;

  logic [SW-1:0] scan_cnt;
  logic [DW-1:0] dwell_cnt;
  logic          scan_wrap, dwell_wrap, frame_end, fd_next;

  // Scan-slot counter runs only while a column is lit.
  modulo_counter #(.MODULUS(SCAN_DIV)) u_scan_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .en_i    (enable && (state_q == ST_ACTIVE)),
    .clr_i   (!enable || (state_q != ST_ACTIVE)),
    .count_o (scan_cnt),
    .wrap_o  (scan_wrap)
  );

  // Edge that closes the frame: last active cycle of column 0.
  assign frame_end = scan_wrap && (pos_q == 2'd2);

  // Dwell counter advances once per frame unless forced or held.
  modulo_counter #(.MODULUS(DWELL_FRAMES)) u_dwell_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .en_i    (frame_end && !force_irrigation && !hold_mode),
    .clr_i   (!enable || (frame_end && force_irrigation)),
    .count_o (dwell_cnt),
    .wrap_o  (dwell_wrap)
  );

  // frame_done is registered, so it is raised one cycle ahead of the last
  // column-0 active cycle. With SCAN_DIV == 1 that cycle follows the blank.
  assign fd_next = enable && (pos_q == 2'd2) &&
                   (((SCAN_DIV == 1) && (state_q == ST_BLANK)) ||
                    ((SCAN_DIV >= 2) && (state_q == ST_ACTIVE) && (scan_cnt == SCAN_PRE)));

  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    mode_d   = mode_q;
    col_en_d = col_en_q;
    row_d    = row_q;
    fd_d     = fd_next;

    // Mode settles during the following blank, before row_data samples the mux.
    if (frame_end) begin
      if (force_irrigation) begin
        mode_d = MODE_IRRIGATION;
      end else if (!hold_mode && dwell_wrap) begin
        mode_d = ~mode_q;
      end
    end

    case (state_q)
      ST_IDLE: begin
        col_en_d = '0;
        row_d    = '0;
        if (enable) begin
          state_d = ST_BLANK;
          pos_d   = 2'd0;
        end
      end
      ST_BLANK: begin
        state_d = ST_ACTIVE;
        unique case (pos_q)
          2'd0:    begin row_d = column_2; col_en_d = COL2; end
          2'd1:    begin row_d = column_1; col_en_d = COL1; end
          default: begin row_d = column_0; col_en_d = COL0; end
        endcase
      end
      ST_ACTIVE: begin
        if (scan_wrap) begin
          state_d  = ST_BLANK;
          col_en_d = '0;
          row_d    = '0;
          pos_d    = (pos_q == 2'd2) ? 2'd0 : pos_q + 2'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Dropping enable wins over everything except the retained mode.
    if (!enable) begin
      state_d  = ST_IDLE;
      pos_d    = 2'd0;
      col_en_d = '0;
      row_d    = '0;
      fd_d     = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      pos_q    <= 2'd0;
      mode_q   <= MODE_WATER;
      col_en_q <= '0;
      row_q    <= '0;
      fd_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      mode_q   <= mode_d;
      col_en_q <= col_en_d;
      row_q    <= row_d;
      fd_q     <= fd_d;
    end
  end

  assign mode_select   = mode_q;
  assign column_enable = col_en_q;
  assign row_data      = row_q;
  assign frame_done    = fd_q;

endmodule

// File: tb/tb_matrix_display_scheduler.sv
// ---------------------------------------------------------------------------
// tb_matrix_display_scheduler
// Directed bench for matrix_display_scheduler with SCAN_DIV=4, DWELL_FRAMES=2
// (15-cycle frame). A behavioural model of the scan/dwell rules pushes the
// expected outputs of each cycle into a scoreboard when stimulus is applied;
// the entry is popped and compared once the DUT has produced that cycle.
// ---------------------------------------------------------------------------
module tb_matrix_display_scheduler;

  localparam int SCAN_DIV     = 4;
  localparam int DWELL_FRAMES = 2;
  localparam int SLOT         = SCAN_DIV + 1;
  localparam int FRAME        = 3 * SLOT;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       enable;
  logic       hold_mode;
  logic       force_irrigation;
  logic [6:0] column_2, column_1, column_0;
  logic       mode_select;
  logic [2:0] column_enable;
  logic [6:0] row_data;
  logic       frame_done;

  matrix_display_scheduler #(
    .SCAN_DIV     (SCAN_DIV),
    .DWELL_FRAMES (DWELL_FRAMES)
  ) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .enable           (enable),
    .hold_mode        (hold_mode),
    .force_irrigation (force_irrigation),
    .column_2         (column_2),
    .column_1         (column_1),
    .column_0         (column_0),
    .mode_select      (mode_select),
    .column_enable    (column_enable),
    .row_data         (row_data),
    .frame_done       (frame_done)
  );

  always #5 clock = ~clock;

  typedef struct {
    int         t;
    logic       mode;
    logic [2:0] col;
    logic [6:0] row;
    logic       fd;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  // Model state: t = cycles since scanning started (0 = idle, 1 = first blank).
  int         t       = 0;
  int         m_dwell = 0;
  logic       m_mode  = 1'b0;
  logic [6:0] m_row   = '0;

  task automatic chk(input string tag, input int cyc, input logic [6:0] got,
                     input logic [6:0] exp_v);
    checks++;
    assert (got === exp_v)
    else begin
      errors++;
      $error("FAIL %s t=%0d: got %h expected %h", tag, cyc, got, exp_v);
    end
  endtask

  // Apply the spec rules for the coming edge, push the expectation, clock,
  // then pop and compare.
  task automatic step();
    exp_t e;
    int   p;
    int   slot;
    if (!enable) begin
      t       = 0;
      m_dwell = 0;
    end else begin
      if (t >= 1 && ((t - 1) % FRAME) == FRAME - 1) begin
        if (force_irrigation) begin
          m_mode  = 1'b1;
          m_dwell = 0;
        end else if (!hold_mode) begin
          if (m_dwell == DWELL_FRAMES - 1) begin
            m_mode  = ~m_mode;
            m_dwell = 0;
          end else begin
            m_dwell++;
          end
        end
      end
      t++;
    end
    e.t    = t;
    e.mode = m_mode;
    e.col  = 3'b000;
    e.row  = 7'h00;
    e.fd   = 1'b0;
    if (t >= 1) begin
      p    = (t - 1) % FRAME;
      slot = p / SLOT;
      if ((p % SLOT) != 0) begin
        if ((p % SLOT) == 1) begin
          m_row = (slot == 0) ? column_2 : (slot == 1) ? column_1 : column_0;
        end
        e.col = (slot == 0) ? 3'b100 : (slot == 1) ? 3'b010 : 3'b001;
        e.row = m_row;
        e.fd  = (p == FRAME - 1);
      end
    end
    sb_q.push_back(e);
    @(posedge clock);
    #1;
    e = sb_q.pop_front();
    chk("column_enable", e.t, {4'b0, column_enable}, {4'b0, e.col});
    chk("row_data",      e.t, row_data,              e.row);
    chk("frame_done",    e.t, {6'b0, frame_done},    {6'b0, e.fd});
    chk("mode_select",   e.t, {6'b0, mode_select},   {6'b0, e.mode});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    reset_n          = 1'b1;
    enable           = 1'b0;
    hold_mode        = 1'b0;
    force_irrigation = 1'b0;
    column_2         = 7'h7F;
    column_1         = 7'h2A;
    column_0         = 7'h01;

    // Reset values.
    #3 reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("reset column_enable", 0, {4'b0, column_enable}, 7'h00);
    chk("reset row_data",      0, row_data,              7'h00);
    chk("reset frame_done",    0, {6'b0, frame_done},    7'h00);
    chk("reset mode_select",   0, {6'b0, mode_select},   7'h00);
    @(negedge clock);
    reset_n = 1'b1;

    // Basic scan and free-running dwell: toggles at the 2nd and 4th frame ends.
    enable = 1'b1;
    t      = 0;
    run(70);

    // Hold for 4 frames, release mid-frame; new column_2 word appears next frame.
    hold_mode = 1'b1;
    run(60);
    hold_mode = 1'b0;
    column_2  = 7'h55;
    run(45);
    run(8);
    // Mid-ACTIVE change of column 2 must not show until its next slot.
    column_2 = 7'h33;
    run(15);

    // Force together with hold, asserted mid-frame: force wins at the boundary.
    force_irrigation = 1'b1;
    hold_mode        = 1'b1;
    run(40);

    // Enable drop with force still held: idle, mode retained, then restart.
    enable = 1'b0;
    run(3);
    enable    = 1'b1;
    hold_mode = 1'b0;
    run(40);
    force_irrigation = 1'b0;
    run(5);

    // Reach an ACTIVE cycle, then assert reset with no clock edge.
    for (int i = 0; i < SLOT && !(t >= 1 && (((t - 1) % FRAME) % SLOT) != 0); i++) step();
    #2 reset_n = 1'b0;
    #1;
    chk("async column_enable", t, {4'b0, column_enable}, 7'h00);
    chk("async row_data",      t, row_data,              7'h00);
    chk("async frame_done",    t, {6'b0, frame_done},    7'h00);
    chk("async mode_select",   t, {6'b0, mode_select},   7'h00);
    t       = 0;
    m_dwell = 0;
    m_mode  = 1'b0;
    #2 reset_n = 1'b1;
    run(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
